request_decoder3to8: RTL and testbench

Sequential 3-to-8 grant decoder that takes the encoded output of an 8-to-3 priority encoder (index `y`, valid `z`) and turns it into a registered one-hot grant line. The grant is held until the granted agent acknowledges or a timeout expires, followed by a fixed dead gap. It sits between the request-arbitration encoder and the eight requesting agents, and closes the encode → decode loop.

---
 rtl/request_decoder3to8_pkg.sv | 15 +
 rtl/decoder3to8.sv | 18 +
 rtl/request_decoder3to8.sv | 117 +++++++++++
 tb/tb_request_decoder3to8.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/request_decoder3to8_pkg.sv
// Shared types and widths for the request grant decoder.
package request_decoder3to8_pkg;

   localparam int unsigned CODE_W     = 3;
   localparam int unsigned GRANT_W    = 8;
   localparam int unsigned HOLD_CNT_W = 8;
   localparam int unsigned GAP_CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

endpackage : request_decoder3to8_pkg

// File: rtl/decoder3to8.sv
// Combinational 3-to-8 one-hot decoder with enable.
module decoder3to8
   import request_decoder3to8_pkg::*;
(
   input  logic [CODE_W-1:0]  idx,
   input  logic               en,
   output logic [GRANT_W-1:0] onehot_c
);

   // Drive a single bit selected by idx when enabled.
   always_comb begin
      onehot_c = '0;
      if (en) begin
         onehot_c[idx] = 1'b1;
      end
   end

endmodule : decoder3to8

// File: rtl/request_decoder3to8.sv
// Registered one-hot grant with ack/timeout release and a fixed dead gap.
module request_decoder3to8
   import request_decoder3to8_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [CODE_W-1:0]  y,
   input  logic               z,
   output logic               in_ready,
   input  logic               ack,
   output logic [GRANT_W-1:0] grant,
   output logic               grant_valid,
   output logic [CODE_W-1:0]  last_code,
   output logic               timeout_pulse,
   output logic               timeout_err,
   input  logic               err_clr
);

   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(TIMEOUT - 1);
   localparam logic [GAP_CNT_W-1:0]  GAP_LAST  = GAP_CNT_W'(GAP_CYCLES - 1);

   state_t                  state, state_d;
   logic [HOLD_CNT_W-1:0]   hold_cnt, hold_cnt_d;
   logic [GAP_CNT_W-1:0]    gap_cnt, gap_cnt_d;
   logic [GRANT_W-1:0]      grant_d;
   logic                    grant_valid_d;
   logic [CODE_W-1:0]       last_code_d;
   logic                    timeout_pulse_d;
   logic                    timeout_err_d;
   logic [GRANT_W-1:0]      dec_onehot_c;

   // Requests are only taken while idle.
   assign in_ready = (state == IDLE);

   decoder3to8 u_decoder (
      .idx      (y),
      .en       (z & in_ready),
      .onehot_c (dec_onehot_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d         = state;
      hold_cnt_d      = hold_cnt;
      gap_cnt_d       = gap_cnt;
      grant_d         = grant;
      last_code_d     = last_code;
      timeout_pulse_d = 1'b0;
      timeout_err_d   = err_clr ? 1'b0 : timeout_err;

      case (state)
         IDLE: begin
            if (z) begin
               state_d     = GRANT;
               grant_d     = dec_onehot_c;
               last_code_d = y;
               hold_cnt_d  = '0;
            end
         end
         GRANT: begin
            if (ack) begin
               state_d   = GAP;
               grant_d   = '0;
               gap_cnt_d = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_d         = GAP;
               grant_d         = '0;
               gap_cnt_d       = '0;
               timeout_pulse_d = 1'b1;
               timeout_err_d   = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt + HOLD_CNT_W'(1);
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt + GAP_CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase

      grant_valid_d = |grant_d;
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         gap_cnt       <= '0;
         grant         <= '0;
         grant_valid   <= 1'b0;
         last_code     <= '0;
         timeout_pulse <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         state         <= state_d;
         hold_cnt      <= hold_cnt_d;
         gap_cnt       <= gap_cnt_d;
         grant         <= grant_d;
         grant_valid   <= grant_valid_d;
         last_code     <= last_code_d;
         timeout_pulse <= timeout_pulse_d;
         timeout_err   <= timeout_err_d;
      end
   end

endmodule : request_decoder3to8

// File: tb/tb_request_decoder3to8.sv
// Directed bench for request_decoder3to8 with a per-cycle behavioural model.
module tb_request_decoder3to8;

   localparam int TMO  = 4;
   localparam int GAPC = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] y = 3'd0;
   logic       z = 1'b0;
   logic       ack = 1'b0;
   logic       err_clr = 1'b0;
   logic       in_ready;
   logic [7:0] grant;
   logic       grant_valid;
   logic [2:0] last_code;
   logic       timeout_pulse;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   request_decoder3to8 #(.TIMEOUT(TMO), .GAP_CYCLES(GAPC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .y             (y),
      .z             (z),
      .in_ready      (in_ready),
      .ack           (ack),
      .grant         (grant),
      .grant_valid   (grant_valid),
      .last_code     (last_code),
      .timeout_pulse (timeout_pulse),
      .timeout_err   (timeout_err),
      .err_clr       (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: who owns the grant, how many cycles it has been visible, gap cycles left.
   int         m_owner;
   int         m_held;
   int         m_gap_left;
   logic [2:0] m_last;
   logic       m_err;
   logic       m_pulse;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner    <= -1;
         m_held     <= 0;
         m_gap_left <= 0;
         m_last     <= 3'd0;
         m_err      <= 1'b0;
         m_pulse    <= 1'b0;
      end else begin
         m_pulse <= 1'b0;
         if (m_owner >= 0) begin
            if (ack) begin
               m_owner    <= -1;
               m_gap_left <= GAPC;
            end else if (m_held == TMO) begin
               m_owner    <= -1;
               m_gap_left <= GAPC;
               m_pulse    <= 1'b1;
            end else begin
               m_held <= m_held + 1;
            end
         end else if (m_gap_left > 0) begin
            m_gap_left <= m_gap_left - 1;
         end else if (z) begin
            m_owner <= int'(y);
            m_held  <= 1;
            m_last  <= y;
         end
         if (m_owner >= 0 && !ack && m_held == TMO) begin
            m_err <= 1'b1;
         end else if (err_clr) begin
            m_err <= 1'b0;
         end
      end
   end

   // Compare every output against the model mid-cycle.
   always @(negedge clk) begin
      logic [7:0] eg;
      eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      check("cmp_grant", grant, eg);
      check("cmp_grant_valid", 8'(grant_valid), 8'(eg != 8'h00));
      check("cmp_in_ready", 8'(in_ready), 8'(m_owner < 0 && m_gap_left == 0));
      check("cmp_last_code", 8'(last_code), 8'(m_last));
      check("cmp_timeout_pulse", 8'(timeout_pulse), 8'(m_pulse));
      check("cmp_timeout_err", 8'(timeout_err), 8'(m_err));
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_in_ready", 8'(in_ready), 8'd1);
   endtask

   // Present code for one cycle; returns in the first grant cycle.
   task automatic accept(input logic [2:0] code);
      wait_ready();
      y = code;
      z = 1'b1;
      @(negedge clk);
      z = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_grant", grant, 8'h00);
      check("rst_grant_valid", 8'(grant_valid), 8'd0);
      check("rst_in_ready", 8'(in_ready), 8'd1);
      check("rst_last_code", 8'(last_code), 8'd0);
      check("rst_timeout_err", 8'(timeout_err), 8'd0);
      rst_n = 1'b1;

      // y=5, ack during the third grant cycle
      accept(3'd5);
      for (int k = 0; k < 3; k++) begin
         check("t1_grant", grant, 8'h20);
         check("t1_in_ready", 8'(in_ready), 8'd0);
         if (k == 2) ack = 1'b1;
         @(negedge clk);
      end
      ack = 1'b0;
      check("t1_drop", grant, 8'h00);
      check("t1_last_code", 8'(last_code), 8'd5);
      check("t1_gap_ready", 8'(in_ready), 8'd0);
      @(negedge clk);
      check("t1_ready_back", 8'(in_ready), 8'd1);

      // sweep every index, acked after one cycle
      for (int i = 0; i < 8; i++) begin
         accept(3'(i));
         check("sweep_grant", grant, 8'(1 << i));
         check("sweep_valid", 8'(grant_valid), 8'd1);
         ack = 1'b1;
         @(negedge clk);
         ack = 1'b0;
         check("sweep_drop", grant, 8'h00);
      end
      check("sweep_err", 8'(timeout_err), 8'd0);

      // timeout with no ack
      accept(3'd2);
      for (int k = 0; k < 4; k++) begin
         check("to_grant", grant, 8'h04);
         @(negedge clk);
      end
      check("to_drop", grant, 8'h00);
      check("to_pulse", 8'(timeout_pulse), 8'd1);
      check("to_err", 8'(timeout_err), 8'd1);
      @(negedge clk);
      check("to_pulse_once", 8'(timeout_pulse), 8'd0);
      check("to_err_sticky", 8'(timeout_err), 8'd1);
      @(negedge clk);
      check("to_err_sticky2", 8'(timeout_err), 8'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("to_err_clr", 8'(timeout_err), 8'd0);

      // ack on the last allowed cycle wins over timeout
      accept(3'd3);
      for (int k = 0; k < 4; k++) begin
         check("ackmax_grant", grant, 8'h08);
         if (k == 3) ack = 1'b1;
         @(negedge clk);
      end
      ack = 1'b0;
      check("ackmax_drop", grant, 8'h00);
      check("ackmax_pulse", 8'(timeout_pulse), 8'd0);
      check("ackmax_err", 8'(timeout_err), 8'd0);

      // request during grant is ignored
      accept(3'd1);
      y = 3'd7;
      z = 1'b1;
      for (int k = 0; k < 2; k++) begin
         check("ign_grant", grant, 8'h02);
         check("ign_in_ready", 8'(in_ready), 8'd0);
         check("ign_last_code", 8'(last_code), 8'd1);
         if (k == 1) ack = 1'b1;
         @(negedge clk);
      end
      ack = 1'b0;
      z = 1'b0;
      check("ign_drop", grant, 8'h00);
      accept(3'd7);
      check("ign_next_grant", grant, 8'h80);
      check("ign_next_last", 8'(last_code), 8'd7);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;

      // asynchronous reset in the middle of a grant
      accept(3'd4);
      check("rstmid_grant", grant, 8'h10);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_drop", grant, 8'h00);
      check("rstmid_valid", 8'(grant_valid), 8'd0);
      check("rstmid_ready", 8'(in_ready), 8'd1);
      check("rstmid_last", 8'(last_code), 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      y = 3'd6;
      z = 1'b1;
      @(negedge clk);
      z = 1'b0;

      // timeout set and err_clr in the same cycle: set wins
      for (int k = 0; k < 4; k++) begin
         check("setclr_grant", grant, 8'h40);
         if (k == 3) err_clr = 1'b1;
         @(negedge clk);
      end
      err_clr = 1'b0;
      check("setclr_pulse", 8'(timeout_pulse), 8'd1);
      check("setclr_err", 8'(timeout_err), 8'd1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_request_decoder3to8
